// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// lsu_pkg: shared funct3 codes, FSM states and access-legality helper (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Unsigned variants exist only for loads; halves and words must be naturally aligned.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// lsu_align: store byte enables / lane replication and load extraction (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        st_func3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_data,
  input  logic [2:0]        ld_func3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] w_shifted;

  always_comb begin
    st_be   = 4'b0000;
    st_data = st_wdata;
    case (st_func3)
      F3_B: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_be   = 4'b0011 << st_off;
        st_data = {2{st_wdata[15:0]}};
      end
      F3_W: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = st_wdata;
      end
    endcase
  end

  // Bring the addressed byte/half down to lane 0 before extending.
  assign w_shifted = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = w_shifted;
    case (ld_func3)
      F3_B:    ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   ld_data = {24'd0, w_shifted[7:0]};
      F3_H:    ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   ld_data = {16'd0, w_shifted[15:0]};
      default: ld_data = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_wait_ctrl.sv
//------------------------------------------------------------------------------
// lsu_wait_ctrl: M-stage LSU with req/ready DM handshake and timeout (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module lsu_wait_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_is_store,
  input  logic [2:0]        m_func3,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  output logic              lsu_stall,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_rdata_valid,
  output logic              lsu_fault,
  output logic              lsu_timeout,
  output logic              dm_req,
  output logic [ADDR_W-1:0] dm_address,
  output logic [3:0]        dm_w_en,
  output logic [31:0]       dm_w_data,
  input  logic              dm_ready,
  input  logic [31:0]       dm_read_data
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               C_TO_EN   = (TIMEOUT_CYCLES != 0);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_busy_cycles;
  logic              r_is_store;
  logic [2:0]        r_func3;
  logic [1:0]        r_off;
  logic              w_legal;
  logic              w_start;
  logic              w_illegal;
  logic              w_ready;
  logic              w_timeout;
  logic [3:0]        w_st_be;
  logic [DATA_W-1:0] w_st_data;
  logic [DATA_W-1:0] w_ld_data;

  lsu_align u_align (
    .st_func3 (m_func3),
    .st_off   (m_addr[1:0]),
    .st_wdata (m_wdata),
    .st_be    (w_st_be),
    .st_data  (w_st_data),
    .ld_func3 (r_func3),
    .ld_off   (r_off),
    .ld_word  (dm_read_data),
    .ld_data  (w_ld_data)
  );

  assign w_legal   = access_legal(m_is_store, m_func3, m_addr[1:0]);
  assign w_start   = (r_state == ST_IDLE) && m_valid && w_legal;
  assign w_illegal = (r_state == ST_IDLE) && m_valid && !w_legal;
  assign w_ready   = (r_state == ST_BUSY) && dm_ready;

  // r_count is the number of BUSY cycles already completed, so the abort
  // fires at the end of the TIMEOUT_CYCLES-th BUSY cycle; ready still wins.
  assign w_busy_cycles = r_count + CNT_W'(1);
  assign w_timeout     = C_TO_EN && (r_state == ST_BUSY) && !dm_ready &&
                         (w_busy_cycles == C_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_BUSY;
      ST_BUSY: if (dm_ready || w_timeout) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall = 1'b0;
    case (r_state)
      ST_IDLE: lsu_stall = w_start;
      ST_BUSY: lsu_stall = 1'b1;
      default: lsu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count         <= '0;
      r_is_store      <= 1'b0;
      r_func3         <= 3'b000;
      r_off           <= 2'b00;
      dm_req          <= 1'b0;
      dm_address      <= '0;
      dm_w_en         <= 4'b0000;
      dm_w_data       <= 32'd0;
      lsu_rdata       <= 32'd0;
      lsu_rdata_valid <= 1'b0;
      lsu_fault       <= 1'b0;
      lsu_timeout     <= 1'b0;
    end else begin
      lsu_fault       <= w_illegal;
      lsu_timeout     <= w_timeout;
      lsu_rdata_valid <= w_ready && !r_is_store;

      if (r_state == ST_BUSY) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= '0;
      end

      if (w_start) begin
        r_is_store <= m_is_store;
        r_func3    <= m_func3;
        r_off      <= m_addr[1:0];
        dm_req     <= 1'b1;
        dm_address <= {m_addr[ADDR_W-1:2], 2'b00};
        dm_w_en    <= m_is_store ? w_st_be : 4'b0000;
        dm_w_data  <= m_is_store ? w_st_data : 32'd0;
      end else if (w_ready || w_timeout) begin
        dm_req  <= 1'b0;
        dm_w_en <= 4'b0000;
      end

      if (w_ready && !r_is_store) begin
        lsu_rdata <= w_ld_data;
      end else if (w_timeout) begin
        lsu_rdata <= 32'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_wait_ctrl.sv
//------------------------------------------------------------------------------
// tb_lsu_wait_ctrl: directed + random checks of lsu_wait_ctrl (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_wait_ctrl;

  localparam int ADDR_W = 16;
  localparam int TO     = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m_valid = 1'b0;
  logic              m_is_store = 1'b0;
  logic [2:0]        m_func3 = 3'b000;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_wdata = 32'd0;
  logic              lsu_stall;
  logic [31:0]       lsu_rdata;
  logic              lsu_rdata_valid;
  logic              lsu_fault;
  logic              lsu_timeout;
  logic              dm_req;
  logic [ADDR_W-1:0] dm_address;
  logic [3:0]        dm_w_en;
  logic [31:0]       dm_w_data;
  logic              dm_ready = 1'b0;
  logic [31:0]       dm_read_data = 32'd0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata = 32'd0;

  lsu_wait_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .m_valid         (m_valid),
    .m_is_store      (m_is_store),
    .m_func3         (m_func3),
    .m_addr          (m_addr),
    .m_wdata         (m_wdata),
    .lsu_stall       (lsu_stall),
    .lsu_rdata       (lsu_rdata),
    .lsu_rdata_valid (lsu_rdata_valid),
    .lsu_fault       (lsu_fault),
    .lsu_timeout     (lsu_timeout),
    .dm_req          (dm_req),
    .dm_address      (dm_address),
    .dm_w_en         (dm_w_en),
    .dm_w_data       (dm_w_data),
    .dm_ready        (dm_ready),
    .dm_read_data    (dm_read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes from funct3 (0 = no such access).
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  task automatic run_access(input bit is_st, input logic [2:0] f3, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ready_at);
    int          sz;
    int          off;
    bit          legal;
    bit          hit;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    logic [63:0] v;
    sz    = size_of(f3);
    off   = int'(addr[1:0]);
    legal = (sz != 0) && ((off % (sz == 0 ? 1 : sz)) == 0) && !(is_st && f3[2]);
    be    = 4'b0000;
    wd    = 32'd0;
    ld    = 32'd0;
    if (legal) begin
      if (is_st) begin
        be = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
      end
      v = {32'd0, rdata} >> (8 * off);
      v = v & ((64'd1 << (8 * sz)) - 64'd1);
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
      ld = v[31:0];
    end

    m_valid    = 1'b1;
    m_is_store = is_st;
    m_func3    = f3;
    m_addr     = addr;
    m_wdata    = wdata;
    dm_ready   = 1'b0;
    #1;
    chk1("stall_idle", lsu_stall, legal);
    step();

    if (!legal) begin
      chk1("fault_set", lsu_fault, 1'b1);
      chk1("fault_noreq", dm_req, 1'b0);
      chk1("fault_nostall", lsu_stall, 1'b0);
      m_valid = 1'b0;
      step();
      chk1("fault_pulse", lsu_fault, 1'b0);
      chk1("fault_noreq2", dm_req, 1'b0);
      return;
    end

    for (int k = 1; k <= TO; k++) begin
      dm_ready     = (k == ready_at);
      dm_read_data = (k == ready_at) ? rdata : $urandom;
      #1;
      chk1("busy_req", dm_req, 1'b1);
      chk1("busy_stall", lsu_stall, 1'b1);
      chk32("busy_addr", 32'(dm_address), 32'({addr[15:2], 2'b00}));
      chk32("busy_wen", 32'(dm_w_en), 32'(be));
      if (is_st) chk32("busy_wdata", dm_w_data, wd);
      step();
      if (k == ready_at) break;
    end

    dm_ready = 1'b0;
    hit      = (ready_at >= 1) && (ready_at <= TO);
    if (!hit) exp_rdata = 32'd0;
    else if (!is_st) exp_rdata = ld;
    chk1("done_stall", lsu_stall, 1'b0);
    chk1("done_req", dm_req, 1'b0);
    chk1("done_rvalid", lsu_rdata_valid, !is_st && hit);
    chk1("done_timeout", lsu_timeout, !hit);
    chk32("done_rdata", lsu_rdata, exp_rdata);
    m_valid = 1'b0;
    step();
    chk1("idle_rvalid", lsu_rdata_valid, 1'b0);
    chk1("idle_timeout", lsu_timeout, 1'b0);
    chk1("idle_stall", lsu_stall, 1'b0);
    chk32("idle_rdata", lsu_rdata, exp_rdata);
  endtask

  initial begin
    logic [15:0] ra;
    int          rsel;

    step();
    step();
    chk1("rst_req", dm_req, 1'b0);
    chk32("rst_wen", 32'(dm_w_en), 32'd0);
    chk32("rst_addr", 32'(dm_address), 32'd0);
    chk32("rst_wdata", dm_w_data, 32'd0);
    chk32("rst_rdata", lsu_rdata, 32'd0);
    chk1("rst_rvalid", lsu_rdata_valid, 1'b0);
    chk1("rst_fault", lsu_fault, 1'b0);
    chk1("rst_timeout", lsu_timeout, 1'b0);
    chk1("rst_stall", lsu_stall, 1'b0);
    rst = 1'b0;

    run_access(1'b1, 3'b010, 16'h0104, 32'hDEADBEEF, 32'd0, 2);
    run_access(1'b1, 3'b000, 16'h0013, 32'h000000A5, 32'd0, 1);

    run_access(1'b0, 3'b000, 16'h0003, 32'd0, 32'h80F17F01, 1);
    chk32("lb_lit", lsu_rdata, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 16'h0003, 32'd0, 32'h80F17F01, 2);
    chk32("lbu_lit", lsu_rdata, 32'h00000080);
    run_access(1'b0, 3'b001, 16'h0002, 32'd0, 32'h80F17F01, 3);
    chk32("lh_lit", lsu_rdata, 32'hFFFF80F1);
    run_access(1'b0, 3'b101, 16'h0000, 32'd0, 32'h80F17F01, 1);
    chk32("lhu_lit", lsu_rdata, 32'h00007F01);
    run_access(1'b0, 3'b010, 16'h0000, 32'd0, 32'h80F17F01, 1);
    chk32("lw_lit", lsu_rdata, 32'h80F17F01);

    run_access(1'b0, 3'b010, 16'h0102, 32'd0, 32'd0, 1);
    run_access(1'b0, 3'b011, 16'h0100, 32'd0, 32'd0, 1);
    run_access(1'b1, 3'b011, 16'h0100, 32'h11223344, 32'd0, 1);

    run_access(1'b0, 3'b010, 16'h0200, 32'd0, 32'hCAFEF00D, TO + 1);
    run_access(1'b0, 3'b010, 16'h0204, 32'd0, 32'h12345678, TO);

    // Reset in the second BUSY cycle abandons the access.
    m_valid    = 1'b1;
    m_is_store = 1'b1;
    m_func3    = 3'b010;
    m_addr     = 16'h0300;
    m_wdata    = 32'h55AA55AA;
    dm_ready   = 1'b0;
    step();
    step();
    rst     = 1'b1;
    m_valid = 1'b0;
    step();
    chk1("midrst_req", dm_req, 1'b0);
    chk32("midrst_wen", 32'(dm_w_en), 32'd0);
    chk32("midrst_addr", 32'(dm_address), 32'd0);
    chk32("midrst_wdata", dm_w_data, 32'd0);
    chk1("midrst_stall", lsu_stall, 1'b0);
    chk32("midrst_rdata", lsu_rdata, 32'd0);
    rst       = 1'b0;
    exp_rdata = 32'd0;
    run_access(1'b1, 3'b010, 16'h0304, 32'h0BADBEEF, 32'd0, 1);

    for (int n = 0; n < 80; n++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rsel = int'($urandom_range(0, 9));
      run_access(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                 $urandom, (rsel == 0) ? TO + 1 : int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
